// File: rtl/stream_mux_rr_if.sv
// Stream bundle for the N:1 packet mux: per-channel producer inputs and one registered output.
// master = environment side, slave = mux side.
interface stream_mux_rr_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned CH_W = $clog2(N_CH)
);
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_last;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [CH_W-1:0]   out_ch;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with packet-granular round-robin or fixed-priority arbitration.
// A channel that starts a packet holds the output until its last beat; the output is registered.
module stream_mux_rr #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned W          = 4,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned CH_W       = $clog2(N_CH)
) (
  input logic              clk,
  input logic              rst_n,
  stream_mux_rr_if.slave   bus
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic              load;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic              xfer;
  logic [N_CH-1:0]   grant_oh;
  int                idx;

  assign load = !out_valid_q || bus.out_ready;
  assign xfer = grant_vld && load;

  // Winner selection; the RR scan runs from the highest offset down so the
  // channel closest to the pointer is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    if (state_q == StLocked) begin
      grant_vld = bus.in_valid[lock_ch_q];
      grant_ch  = lock_ch_q;
    end else if (FIXED_PRIO != 0) begin
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        if (bus.in_valid[k]) begin
          grant_vld = 1'b1;
          grant_ch  = CH_W'(k);
        end
      end
    end else begin
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % int'(N_CH);
        if (bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant_ch  = CH_W'(idx);
        end
      end
    end
  end

  // Ready is forced low while reset is asserted so no producer sees a phantom handshake.
  always_comb begin
    grant_oh           = '0;
    grant_oh[grant_ch] = 1'b1;
    bus.in_ready       = (rst_n && xfer) ? grant_oh : '0;
  end

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(grant_ch) * int'(W) +: W];
      out_last_d  = bus.in_last[grant_ch];
      out_ch_d    = grant_ch;
      if (bus.in_last[grant_ch]) begin
        state_d  = StIdle;
        rr_ptr_d = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end else begin
        state_d   = StLocked;
        lock_ch_d = grant_ch;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: one round-robin and one fixed-priority instance, checked every
// cycle against a behavioural packet-arbiter model plus directed literal expectations.
module tb_stream_mux_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(N), .W(W), .CH_W(CW)) bus_rr ();
  stream_mux_rr_if #(.N_CH(N), .W(W), .CH_W(CW)) bus_fp ();

  stream_mux_rr #(.N_CH(N), .W(W), .FIXED_PRIO(0), .CH_W(CW)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  stream_mux_rr #(.N_CH(N), .W(W), .FIXED_PRIO(1), .CH_W(CW)) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  int m_ov[2]   = '{0, 0};
  int m_data[2] = '{0, 0};
  int m_last[2] = '{0, 0};
  int m_ch[2]   = '{0, 0};
  int m_lk[2]   = '{0, 0};
  int m_lkch[2] = '{0, 0};
  int m_ptr[2]  = '{0, 0};
  int n_ov[2]   = '{0, 0};
  int n_data[2] = '{0, 0};
  int n_last[2] = '{0, 0};
  int n_ch[2]   = '{0, 0};
  int n_lk[2]   = '{0, 0};
  int n_lkch[2] = '{0, 0};
  int n_ptr[2]  = '{0, 0};
  int sb_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov <= '{0, 0}; m_data <= '{0, 0}; m_last <= '{0, 0}; m_ch <= '{0, 0};
      m_lk <= '{0, 0}; m_lkch <= '{0, 0}; m_ptr <= '{0, 0};
    end else begin
      m_ov <= n_ov; m_data <= n_data; m_last <= n_last; m_ch <= n_ch;
      m_lk <= n_lk; m_lkch <= n_lkch; m_ptr <= n_ptr;
    end
  end

  task automatic model_cycle(input int d, input logic [N-1:0] v, input logic [N*W-1:0] data,
                             input logic [N-1:0] last, input logic ordy, input logic [N-1:0] rdy,
                             input logic ov, input logic [W-1:0] od, input logic ol,
                             input logic [CW-1:0] och);
    string tag;
    int    g;
    int    c;
    bit    found;
    int    exp_rdy;
    int    beat;
    tag = (d == 0) ? "rr" : "fp";
    chk({tag, ".out_valid"}, ov, m_ov[d]);
    chk({tag, ".out_data"}, od, m_data[d]);
    chk({tag, ".out_last"}, ol, m_last[d]);
    chk({tag, ".out_ch"}, och, m_ch[d]);
    found = 0;
    g     = 0;
    if (rst_n) begin
      if (m_lk[d] != 0) begin
        g     = m_lkch[d];
        found = v[g];
      end else begin
        for (int k = 0; k < int'(N); k++) begin
          c = (d == 0) ? (m_ptr[d] + k) % int'(N) : k;
          if (!found && v[c]) begin
            found = 1;
            g     = c;
          end
        end
      end
    end
    exp_rdy = (found && (m_ov[d] == 0 || ordy)) ? (1 << g) : 0;
    chk({tag, ".in_ready"}, rdy, exp_rdy);

    n_ov[d] = m_ov[d]; n_data[d] = m_data[d]; n_last[d] = m_last[d]; n_ch[d] = m_ch[d];
    n_lk[d] = m_lk[d]; n_lkch[d] = m_lkch[d]; n_ptr[d] = m_ptr[d];
    if (!rst_n) begin
      n_ov[d] = 0; n_data[d] = 0; n_last[d] = 0; n_ch[d] = 0;
      n_lk[d] = 0; n_lkch[d] = 0; n_ptr[d] = 0;
    end else if (exp_rdy != 0) begin
      n_ov[d]   = 1;
      n_data[d] = int'(data[g*W +: W]);
      n_last[d] = int'(last[g]);
      n_ch[d]   = g;
      if (last[g]) begin
        n_lk[d]  = 0;
        n_ptr[d] = (g + 1) % int'(N);
      end else begin
        n_lk[d]   = 1;
        n_lkch[d] = g;
      end
    end else if (ordy) begin
      n_ov[d] = 0;
    end

    // Scoreboard on the RR instance: every accepted beat leaves exactly once, in order.
    if (d == 0) begin
      if (!rst_n) begin
        sb_q.delete();
      end else begin
        if (m_ov[d] != 0 && ordy) begin
          chk("rr.sb_nonempty", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            beat = sb_q.pop_front();
            chk("rr.sb_beat", int'({och, od, ol}), beat);
          end
        end
        if (exp_rdy != 0) sb_q.push_back((g << 5) | (int'(data[g*W +: W]) << 1) | int'(last[g]));
      end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, bus_rr.in_valid, bus_rr.in_data, bus_rr.in_last, bus_rr.out_ready,
                bus_rr.in_ready, bus_rr.out_valid, bus_rr.out_data, bus_rr.out_last,
                bus_rr.out_ch);
    model_cycle(1, bus_fp.in_valid, bus_fp.in_data, bus_fp.in_last, bus_fp.out_ready,
                bus_fp.in_ready, bus_fp.out_valid, bus_fp.out_data, bus_fp.out_last,
                bus_fp.out_ch);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int seq[5] = '{1, 2, 3, 0, 1};
  logic [N-1:0]   rv;
  logic [N-1:0]   rl;
  logic [N*W-1:0] rd;
  logic           ro;

  initial begin
    bus_rr.in_valid = '0; bus_rr.in_data = '0; bus_rr.in_last = '0; bus_rr.out_ready = 1'b1;
    bus_fp.in_valid = '0; bus_fp.in_data = '0; bus_fp.in_last = '0; bus_fp.out_ready = 1'b1;

    // Reset held with every channel valid.
    bus_rr.in_valid = 4'b1111;
    bus_rr.in_last  = 4'b1111;
    bus_rr.in_data  = {4'd3, 4'd2, 4'd1, 4'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", bus_rr.out_valid, 0);
    chk("rst.in_ready", bus_rr.in_ready, 0);
    chk("rst.out_ch", bus_rr.out_ch, 0);
    rst_n = 1'b1;
    #1;
    chk("rst.first_grant", bus_rr.in_ready, 4'b0001);
    step();
    chk("rst.first_valid", bus_rr.out_valid, 1);
    chk("rst.first_ch", bus_rr.out_ch, 0);

    // Round-robin over single-beat packets, one beat per cycle.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr.seq_valid", bus_rr.out_valid, 1);
      chk("rr.seq_ch", bus_rr.out_ch, seq[i]);
      chk("rr.seq_data", bus_rr.out_data, seq[i]);
    end

    // Pointer now at ch2: ch2 sends A,B,C while ch0/ch1 compete.
    bus_rr.in_valid = 4'b0111;
    bus_rr.in_last  = 4'b0011;
    bus_rr.in_data  = {4'h3, 4'hA, 4'h1, 4'h0};
    #1 chk("lock.rdy_a", bus_rr.in_ready, 4'b0100);
    step();
    chk("lock.data_a", bus_rr.out_data, 4'hA);
    chk("lock.ch_a", bus_rr.out_ch, 2);
    bus_rr.in_data[11:8] = 4'hB;
    #1 chk("lock.rdy_b", bus_rr.in_ready, 4'b0100);
    step();
    chk("lock.data_b", bus_rr.out_data, 4'hB);
    bus_rr.in_data[11:8] = 4'hC;
    bus_rr.in_last[2]    = 1'b1;
    bus_rr.in_valid      = 4'b1111;
    #1 chk("lock.rdy_c", bus_rr.in_ready, 4'b0100);
    step();
    chk("lock.data_c", bus_rr.out_data, 4'hC);
    chk("lock.last_c", bus_rr.out_last, 1);
    chk("lock.ch_c", bus_rr.out_ch, 2);
    #1 chk("lock.next_ch3", bus_rr.in_ready, 4'b1000);

    // Backpressure with only ch1 valid.
    bus_rr.in_valid = 4'b0010;
    bus_rr.in_last  = 4'b1111;
    bus_rr.in_data  = {4'h0, 4'h0, 4'h5, 4'h0};
    #1 chk("bp.rdy_pre", bus_rr.in_ready, 4'b0010);
    step();
    chk("bp.data_pre", bus_rr.out_data, 5);
    bus_rr.out_ready = 1'b0;
    bus_rr.in_data   = {4'h0, 4'h0, 4'h6, 4'h0};
    #1 chk("bp.rdy_stall", bus_rr.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.hold_valid", bus_rr.out_valid, 1);
      chk("bp.hold_data", bus_rr.out_data, 5);
      chk("bp.hold_ch", bus_rr.out_ch, 1);
      chk("bp.hold_rdy", bus_rr.in_ready, 0);
    end
    bus_rr.out_ready = 1'b1;
    #1 chk("bp.rdy_resume", bus_rr.in_ready, 4'b0010);
    step();
    chk("bp.data_6", bus_rr.out_data, 6);
    bus_rr.in_data = {4'h0, 4'h0, 4'h7, 4'h0};
    step();
    chk("bp.data_7", bus_rr.out_data, 7);

    // Reset after beat 2 of a 4-beat ch1 packet.
    bus_rr.in_last = 4'b0000;
    bus_rr.in_data = {4'h0, 4'h0, 4'h1, 4'h0};
    step();
    bus_rr.in_data = {4'h0, 4'h0, 4'h2, 4'h0};
    step();
    chk("mrst.beat2", bus_rr.out_data, 2);
    bus_rr.in_valid = 4'b0011;
    bus_rr.in_last  = 4'b0001;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", bus_rr.out_valid, 0);
    chk("mrst.out_data", bus_rr.out_data, 0);
    chk("mrst.out_ch", bus_rr.out_ch, 0);
    chk("mrst.in_ready", bus_rr.in_ready, 0);
    step();
    rst_n = 1'b1;
    #1 chk("mrst.ch0_wins", bus_rr.in_ready, 4'b0001);
    bus_rr.in_valid = '0;

    // Fixed priority: ch1 starves ch3 until it drops valid.
    bus_fp.in_valid = 4'b1010;
    bus_fp.in_last  = 4'b1111;
    bus_fp.in_data  = {4'd3, 4'd2, 4'd1, 4'd0};
    #1 chk("fp.rdy_ch1", bus_fp.in_ready, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fp.ch1", bus_fp.out_ch, 1);
      chk("fp.valid", bus_fp.out_valid, 1);
    end
    bus_fp.in_valid = 4'b1000;
    #1 chk("fp.rdy_ch3", bus_fp.in_ready, 4'b1000);
    step();
    chk("fp.ch3", bus_fp.out_ch, 3);
    bus_fp.in_valid = '0;
    step();

    // Randomised traffic, identical on both instances; multi-beat packets arise naturally.
    for (int i = 0; i < 3000; i++) begin
      rv = N'($urandom);
      rd = (N*W)'($urandom);
      for (int c = 0; c < int'(N); c++) rl[c] = ($urandom_range(0, 2) == 0);
      ro = ($urandom_range(0, 3) != 0);
      bus_rr.in_valid = rv; bus_rr.in_data = rd; bus_rr.in_last = rl; bus_rr.out_ready = ro;
      bus_fp.in_valid = rv; bus_fp.in_data = rd; bus_fp.in_last = rl; bus_fp.out_ready = ro;
      step();
    end

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
